// File: rtl/rv32_mem_arb_defs.sv
// rv32_mem_arb_defs: shared state encoding and constants for the memory arbiter
package rv32_mem_arb_defs;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY_I = 3'd1,
    ST_BUSY_D = 3'd2,
    ST_DONE_I = 3'd3,
    ST_DONE_D = 3'd4
  } arb_state_t;
  localparam logic [2:0] UBHW_WORD = 3'b010;
  localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/arb_streak_cnt.sv
// arb_streak_cnt: saturating count of contested data grants, used to force a fetch grant
module arb_streak_cnt #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  logic [3:0] r_cnt;
  assign sat = (r_cnt == 4'(MAX));
  // count up on contested data grants, stop at MAX, clear on a fetch grant
  always_ff @(posedge clk) begin
    if (!rst) r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (inc && !sat) r_cnt <= r_cnt + 4'd1;
  end
endmodule

// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one memory port between instruction fetch and data access
module rv32_mem_arbiter
  import rv32_mem_arb_defs::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_ubhw,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_ubhw,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);
  arb_state_t        r_state;
  logic              r_cancel;
  logic              r_if_ack;
  logic              r_d_ack;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [2:0]        r_mem_ubhw;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              w_idle;
  logic              w_sat;
  logic              w_grant_d;
  logic              w_grant_i;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_grant_d = w_idle & d_req & ~(if_req & w_sat);
  assign w_grant_i = w_idle & if_req & ~w_grant_d;

  arb_streak_cnt #(.MAX(STARVE_MAX)) u_streak (
    .clk (clk),
    .rst (rst),
    .inc (w_grant_d & if_req),
    .clr (w_grant_i),
    .sat (w_sat)
  );

  assign if_ack    = r_if_ack & ~if_cancel;
  assign d_ack     = r_d_ack;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_ubhw  = r_mem_ubhw;
  assign busy      = ~w_idle;
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

  // arbitration FSM: grant in IDLE, hold the bus until mem_ready, pulse the ack in DONE
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cancel    <= 1'b0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_ubhw  <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cancel <= 1'b0;
          if (w_grant_d) begin
            r_state     <= ST_BUSY_D;
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_mem_ubhw  <= d_ubhw;
          end else if (w_grant_i) begin
            r_state     <= ST_BUSY_I;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_mem_ubhw  <= UBHW_WORD;
          end
        end
        ST_BUSY_I: begin
          if (if_cancel) r_cancel <= 1'b1;
          if (mem_ready) begin
            r_state    <= ST_DONE_I;
            r_mem_req  <= 1'b0;
            r_if_rdata <= mem_rdata;
            r_if_ack   <= ~(r_cancel | if_cancel);
          end
        end
        ST_BUSY_D: begin
          if (mem_ready) begin
            r_state   <= ST_DONE_D;
            r_mem_req <= 1'b0;
            r_d_ack   <= 1'b1;
            if (!r_mem_we) r_d_rdata <= mem_rdata;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_cancel <= 1'b0;
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb_rv32_mem_arbiter: directed vector bench for the fetch/data memory arbiter
module tb_rv32_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, if_cancel = 1'b0, if_ack;
  logic [31:0] if_addr = '0, if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_ack;
  logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic [2:0]  d_ubhw = '0, mem_ubhw;
  logic        mem_req, mem_we, mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic        stall_if, stall_mem, busy;
  int          n_cmp = 0, n_fail = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ubhw;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_rdata;
  } dvec_t;
  dvec_t vt[4];

  always #5 clk = ~clk;

  rv32_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ubhw(d_ubhw),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ubhw(mem_ubhw), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic d_txn(input dvec_t v);
    int nreq;
    nreq = 0;
    d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_ubhw = v.ubhw;
    mem_rdata = v.rdata; mem_ready = 1'b0;
    for (int c = 1; c <= v.delay + 1; c++) begin
      @(negedge clk);
      if (mem_req) nreq++;
      if (c == 1) begin
        check("d_mem_we", mem_we, v.we);
        check("d_mem_addr", mem_addr, v.addr);
        check("d_mem_ubhw", mem_ubhw, v.ubhw);
        if (v.we) check("d_mem_wdata", mem_wdata, v.wdata);
        check("d_stall_mem_busy", stall_mem, 1);
      end
      if (c == v.delay + 1) mem_ready = 1'b1;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    check("d_ack", d_ack, 1);
    check("d_rdata", d_rdata, v.exp_rdata);
    check("d_no_if_ack", if_ack, 0);
    check("d_mem_req_drop", mem_req, 0);
    check("d_stall_mem_ack", stall_mem, 0);
    check("d_req_cycles", nreq, v.delay + 1);
    d_req = 1'b0;
    @(negedge clk);
    check("d_ack_pulse", d_ack, 0);
    check("d_idle", busy, 0);
  endtask

  task automatic i_txn(input logic [31:0] addr, input logic [31:0] rdata, input int delay,
                       input int cancel_cyc, input bit mask_done, input bit exp_ack);
    int nreq;
    nreq = 0;
    if_req = 1'b1; if_addr = addr; mem_rdata = rdata; mem_ready = 1'b0;
    for (int c = 1; c <= delay + 1; c++) begin
      @(negedge clk);
      if_cancel = (c == cancel_cyc);
      if (mem_req) nreq++;
      if (c == 1) begin
        check("i_mem_addr", mem_addr, addr);
        check("i_mem_we", mem_we, 0);
        check("i_mem_ubhw", mem_ubhw, 3'b010);
      end
      if (c == delay + 1) mem_ready = 1'b1;
    end
    @(negedge clk);
    if_cancel = 1'b0;
    mem_ready = 1'b0;
    if (mask_done) begin
      if_cancel = 1'b1;
      #1;
    end
    check("i_ack", if_ack, exp_ack);
    if (exp_ack) check("i_rdata", if_rdata, rdata);
    check("i_no_d_ack", d_ack, 0);
    check("i_req_cycles", nreq, delay + 1);
    if_cancel = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    check("i_ack_pulse", if_ack, 0);
    check("i_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string exp_s;
    int    ng;
    bit    prev;
    bit    got;
    int    lat;
    vt[0] = '{1'b0, 32'h40,  32'h0,        3'b010, 32'hDEADBEEF, 0, 32'hDEADBEEF};
    vt[1] = '{1'b1, 32'h80,  32'h12345678, 3'b001, 32'hAAAA5555, 0, 32'hDEADBEEF};
    vt[2] = '{1'b0, 32'h100, 32'h0,        3'b100, 32'h000000A5, 2, 32'h000000A5};
    vt[3] = '{1'b1, 32'h104, 32'hCAFEF00D, 3'b000, 32'h11111111, 1, 32'h000000A5};

    rst = 1'b0; if_req = 1'b1; d_req = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_acks", {if_ack, d_ack}, 0);
    check("rst_rdata", {if_rdata, d_rdata}, 0);
    check("rst_mem_regs", {mem_we, mem_ubhw, mem_addr}, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    if_req = 1'b0; d_req = 1'b0; rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) d_txn(vt[i]);

    i_txn(32'h1000, 32'h00000013, 0, 0, 1'b0, 1'b1);
    i_txn(32'h1004, 32'h00100093, 3, 2, 1'b0, 1'b0);
    i_txn(32'h2000, 32'h00208133, 0, 0, 1'b0, 1'b1);
    i_txn(32'h2004, 32'hFFFFFFFF, 1, 0, 1'b1, 1'b0);
    i_txn(32'h2008, 32'h0000006F, 0, 0, 1'b0, 1'b1);

    exp_s = "DDDDIDDDDI";
    ng = 0; prev = 1'b0;
    if_req = 1'b1; if_addr = 32'h3000; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    d_ubhw = 3'b010; mem_rdata = 32'h5A5A5A5A; mem_ready = 1'b1;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      @(negedge clk);
      if (d_ack | if_ack) begin
        check("ack_single_pulse", prev, 0);
        check($sformatf("grant%0d", ng), if_ack ? 8'h49 : 8'h44, exp_s[ng]);
        if (d_ack) check("stall_if_while_d", stall_if, 1);
        ng++;
      end
      prev = d_ack | if_ack;
    end
    check("grant_count", ng, 10);
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("prio_idle", busy, 0);

    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; mem_ready = 1'b0; mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    check("mid_busy_req", mem_req, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_mem_req", mem_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_d_ack", d_ack, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    rst = 1'b1; mem_ready = 1'b1;
    got = 1'b0; lat = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (d_ack) begin
        got = 1'b1;
        lat = c;
        break;
      end
    end
    check("reserve_ack", got, 1);
    check("reserve_latency", lat, 2);
    check("reserve_rdata", d_rdata, 32'h0BADF00D);
    d_req = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
